// File: rtl/key_scan_sched.sv
// Round-robin debounce scheduler: one shared engine services NKEY buttons, debounced edges queue in a FWFT FIFO.
// Define KEY_REL_EVT_EN to queue release events as well as presses (default: presses only, EVT_REL tied 0).
module key_scan_sched #(
  parameter int NKEY     = 4,
  parameter int KW       = 2,
  parameter int CW       = 4,
  parameter int HI_TH    = 12,
  parameter int LO_TH    = 7,
  parameter int SCAN_DIV = 1,
  parameter int FDEPTH   = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NKEY-1:0] KIN,
  output logic [NKEY-1:0] KOUT,
  output logic            EVT_VALID,
  output logic [KW-1:0]   EVT_CODE,
  output logic            EVT_REL,
  input  logic            EVT_ACK,
  output logic            OVF,
  input  logic            CLR_OVF
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [KW-1:0] IDX_LAST = KW'(NKEY - 1);
  localparam logic [CW:0]   HI_W     = (CW+1)'(HI_TH);
  localparam logic [CW:0]   LO_W     = (CW+1)'(LO_TH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FDEPTH);

  logic [NKEY-1:0] meta_q, sync_q;
  logic [DW-1:0]   div_q, div_d;
  logic [KW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q [NKEY];
  logic [CW-1:0]   cnt_d;
  logic [NKEY-1:0] kout_q, kout_d;
  logic            slot, samp, flip, det;
  logic [CW:0]     cnt_inc, th;

  logic            pend_q;
  logic [KW-1:0]   pcode_q;
  logic [KW-1:0]   code_mem [FDEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     fcnt_q, fcnt_d;
  logic            full, push, pop, drop;
  logic            ovf_q, ovf_d;

  // Scan slot and the shared debounce engine for key idx_q
  always_comb begin
    slot    = (div_q == DIV_LAST);
    div_d   = slot ? '0 : div_q + 1'b1;
    idx_d   = idx_q;
    if (slot) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    samp    = sync_q[idx_q];
    th      = kout_q[idx_q] ? LO_W : HI_W;
    cnt_inc = {1'b0, cnt_q[idx_q]} + 1'b1;
    flip    = slot && (samp != kout_q[idx_q]) && (cnt_inc > th);
    kout_d  = kout_q;
    if (flip) kout_d[idx_q] = samp;
    cnt_d   = ((samp == kout_q[idx_q]) || flip) ? '0 : cnt_inc[CW-1:0];
`ifdef KEY_REL_EVT_EN
    det     = flip;
`else
    det     = flip && samp;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q <= '0;
      sync_q <= '0;
      div_q  <= '0;
      idx_q  <= '0;
      kout_q <= '0;
      pend_q <= 1'b0;
      for (int k = 0; k < NKEY; k++) cnt_q[k] <= '0;
    end else begin
      meta_q <= KIN;
      sync_q <= meta_q;
      div_q  <= div_d;
      idx_q  <= idx_d;
      kout_q <= kout_d;
      pend_q <= det;
      if (slot) cnt_q[idx_q] <= cnt_d;
    end
  end

  // Event stage: detected edge waits one cycle before entering the FIFO
`ifdef KEY_REL_EVT_EN
  logic prel_q;
  logic rel_mem [FDEPTH];
  always_ff @(posedge CLK) begin
    if (det) prel_q <= ~samp;
    if (push) rel_mem[wptr_q] <= prel_q;
  end
  assign EVT_REL = EVT_VALID ? rel_mem[rptr_q] : 1'b0;
`else
  assign EVT_REL = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (det) pcode_q <= idx_q;
    if (push) code_mem[wptr_q] <= pcode_q;
  end

  // FIFO control; a full FIFO accepts a push only when the head pops on the same edge
  always_comb begin
    EVT_VALID = (fcnt_q != '0);
    full      = (fcnt_q == FULL_CNT);
    pop       = EVT_VALID && EVT_ACK;
    push      = pend_q && (!full || pop);
    drop      = pend_q && full && !pop;
    fcnt_d    = fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d     = drop | (ovf_q & ~CLR_OVF);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      fcnt_q <= fcnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign EVT_CODE = EVT_VALID ? code_mem[rptr_q] : '0;
  assign KOUT     = kout_q;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_key_scan_sched.sv
// Bench for key_scan_sched: directed scenarios with literal expectations plus randomized key/ack traffic
// checked every cycle against a behavioural model (sample stream, per-key run lengths, event queue).
module tb_key_scan_sched;
  localparam int NKEY = 4, KW = 2, CW = 4, HI_TH = 12, LO_TH = 7, SCAN_DIV = 1, FDEPTH = 4;
`ifdef KEY_REL_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [NKEY-1:0] KIN = '0;
  logic [NKEY-1:0] KOUT;
  logic            EVT_VALID;
  logic [KW-1:0]   EVT_CODE;
  logic            EVT_REL;
  logic            EVT_ACK = 1'b0;
  logic            OVF;
  logic            CLR_OVF = 1'b0;

  int checks = 0;
  int errors = 0;

  key_scan_sched #(.NKEY(NKEY), .KW(KW), .CW(CW), .HI_TH(HI_TH), .LO_TH(LO_TH),
                   .SCAN_DIV(SCAN_DIV), .FDEPTH(FDEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .KIN(KIN), .KOUT(KOUT), .EVT_VALID(EVT_VALID),
    .EVT_CODE(EVT_CODE), .EVT_REL(EVT_REL), .EVT_ACK(EVT_ACK), .OVF(OVF), .CLR_OVF(CLR_OVF));

  always #5 CLK = ~CLK;

  typedef struct { int code; bit rel; } evt_t;
  evt_t            m_q[$];
  evt_t            m_pend;
  bit              m_pend_v;
  bit [NKEY-1:0]   m_kout, m_h1, m_h2;
  int              m_run[NKEY];
  int              m_tick;
  bit              m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: samples arrive two edges late; slot n services key n mod NKEY; events land in the queue one edge later
  task automatic model_step();
    bit [NKEY-1:0] s;
    int k, th;
    bit pop, drop;
    if (!RST_N) begin
      m_q.delete();
      m_pend_v = 0;
      m_kout = '0; m_h1 = '0; m_h2 = '0;
      m_tick = 0;
      m_ovf = 0;
      for (int i = 0; i < NKEY; i++) m_run[i] = 0;
      return;
    end
    pop = (m_q.size() != 0) && EVT_ACK;
    drop = 0;
    if (pop) m_q.delete(0);
    if (m_pend_v) begin
      if (m_q.size() < FDEPTH) m_q.push_back(m_pend);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (CLR_OVF) m_ovf = 0;
    m_pend_v = 0;
    s = m_h2; m_h2 = m_h1; m_h1 = KIN;
    if ((m_tick % SCAN_DIV) == SCAN_DIV - 1) begin
      k = (m_tick / SCAN_DIV) % NKEY;
      th = m_kout[k] ? LO_TH : HI_TH;
      if (s[k] == m_kout[k]) m_run[k] = 0;
      else begin
        m_run[k]++;
        if (m_run[k] > th) begin
          m_kout[k] = s[k];
          m_run[k] = 0;
          if (REL_EN || s[k]) begin
            m_pend_v = 1;
            m_pend.code = k;
            m_pend.rel = !s[k];
          end
        end
      end
    end
    m_tick++;
  endtask

  initial forever begin
    @(posedge CLK or negedge RST_N);
    model_step();
  end

  task automatic compare();
    chk("kout", KOUT, m_kout);
    chk("evt_valid", EVT_VALID, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("evt_code", EVT_CODE, m_q[0].code);
      chk("evt_rel", EVT_REL, m_q[0].rel);
    end
    chk("ovf", OVF, m_ovf);
  endtask

  initial forever begin
    @(posedge CLK);
    #1;
    compare();
  end

  task automatic to_edge(input int n);
    while (m_tick < n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic apply_reset(input logic [NKEY-1:0] kin_val);
    RST_N = 1'b0; KIN = kin_val; EVT_ACK = 1'b0; CLR_OVF = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_kout", KOUT, 0);
    chk("rst_valid", EVT_VALID, 0);
    chk("rst_ovf", OVF, 0);
    RST_N = 1'b1;
  endtask

  initial begin
    int ackpush, w;
    logic [NKEY-1:0] tgt, kin_n;
    int ackdiv;
    #1;
    // Keys held through reset: key2 first (13th service at edge 51), then 3, 0, 1
    apply_reset(4'hF);
    to_edge(50); chk("T1_kout_e50", KOUT, 4'b0000);
    to_edge(51); chk("T1_kout_e51", KOUT, 4'b0100);
    to_edge(52); chk("T1_code_e52", EVT_CODE, 2);
    to_edge(54); chk("T1_kout_e54", KOUT, 4'b1111);

    // Single press with one-cycle event latency, then ack
    apply_reset(4'b0100);
    to_edge(50); chk("T2_kout_e50", KOUT, 4'b0000);
    to_edge(51); chk("T2_kout_e51", KOUT, 4'b0100); chk("T2_valid_e51", EVT_VALID, 0);
    to_edge(52); chk("T2_valid_e52", EVT_VALID, 1); chk("T2_code", EVT_CODE, 2); chk("T2_rel", EVT_REL, 0);
    EVT_ACK = 1'b1;
    to_edge(53); EVT_ACK = 1'b0; chk("T2_valid_ack", EVT_VALID, 0);

    // Release after 8 low services of key 2
    KIN = 4'b0000;
    to_edge(86); chk("T4_kout_e86", KOUT, 4'b0100);
    to_edge(87); chk("T4_kout_e87", KOUT, 4'b0000);
    to_edge(88); chk("T4_valid", EVT_VALID, REL_EN); chk("T4_rel", EVT_REL, REL_EN);
    EVT_ACK = 1'b1;
    to_edge(89); EVT_ACK = 1'b0; chk("T4_drained", EVT_VALID, 0);

    // Bounce: 12 high services, one low, then 13 high -> one press at edge 106
    apply_reset(4'b0010);
    to_edge(48); KIN = 4'b0000;
    to_edge(52); KIN = 4'b0010;
    to_edge(105); chk("T3_kout_e105", KOUT, 4'b0000); chk("T3_valid_e105", EVT_VALID, 0);
    to_edge(106); chk("T3_kout_e106", KOUT, 4'b0010);
    to_edge(107); chk("T3_valid", EVT_VALID, 1); chk("T3_code", EVT_CODE, 1); chk("T3_rel", EVT_REL, 0);
    EVT_ACK = 1'b1;
    to_edge(108); EVT_ACK = 1'b0; chk("T3_single", EVT_VALID, 0);

    // Overflow: four presses fill the FIFO, later events drop
    apply_reset(4'hF);
    to_edge(60); KIN = 4'b1110;
    to_edge(100); KIN = 4'b1111;
    to_edge(160); chk("T5_ovf", OVF, 1); chk("T5_head0", EVT_CODE, 2);
    CLR_OVF = 1'b1; EVT_ACK = 1'b1;
    to_edge(161); CLR_OVF = 1'b0; chk("T5_ovf_clr", OVF, 0); chk("T5_head1", EVT_CODE, 3);
    to_edge(162); chk("T5_head2", EVT_CODE, 0);
    to_edge(163); chk("T5_head3", EVT_CODE, 1);
    to_edge(164); chk("T5_empty", EVT_VALID, 0);
    EVT_ACK = 1'b0;

    // Full FIFO with ack on each push edge: no drop
    apply_reset(4'hF);
    to_edge(60); KIN = 4'b1101;
    ackpush = 0;
    while (m_tick < 170) begin
      EVT_ACK = m_pend_v;
      if (m_pend_v) ackpush++;
      if (m_tick == 110) KIN = 4'b1111;
      @(posedge CLK);
      #1;
    end
    EVT_ACK = 1'b0;
    chk("T5_noovf", OVF, 0);
    chk("T5_full_valid", EVT_VALID, 1);
    chk("T5_ackpush", ackpush, REL_EN ? 2 : 1);

    // Async reset mid-count with a non-empty FIFO
    KIN = 4'b1110;
    w = 0;
    while (m_run[0] != 6 && w < 100) begin
      @(posedge CLK);
      #1;
      w++;
    end
    chk("T6_reach_cnt6", w < 100, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("T6_valid", EVT_VALID, 0);
    chk("T6_kout", KOUT, 0);
    chk("T6_code", EVT_CODE, 0);
    chk("T6_ovf", OVF, 0);
    KIN = 4'b0001;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    to_edge(52); chk("T6_kout_e52", KOUT, 4'b0000);
    to_edge(53); chk("T6_kout_e53", KOUT, 4'b0001);

    // Randomized traffic: slowly changing keys with glitches, varying ack rate, sporadic resets
    tgt = KIN;
    for (int ph = 0; ph < 3; ph++) begin
      ackdiv = (ph == 0) ? 2 : (ph == 1) ? 60 : 6;
      for (int c = 0; c < 5000; c++) begin
        for (int k = 0; k < NKEY; k++) begin
          if ($urandom_range(0, 79) == 0) tgt[k] = ~tgt[k];
          kin_n[k] = tgt[k] ^ ($urandom_range(0, 24) == 0);
        end
        KIN = kin_n;
        EVT_ACK = ($urandom_range(0, ackdiv - 1) == 0);
        CLR_OVF = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 2999) == 0) begin
          #3;
          RST_N = 1'b0;
          @(posedge CLK);
          #1;
          RST_N = 1'b1;
        end else begin
          @(posedge CLK);
          #1;
        end
      end
    end
    EVT_ACK = 1'b0;
    CLR_OVF = 1'b0;
    @(posedge CLK);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
